// File: rtl/gbvga_pkg.sv
// Shared constants and types for the Game Boy capture / VGA scan-out slice.
package gbvga_pkg;

  localparam int GB_H_PIXELS     = 160;
  localparam int GB_V_LINES      = 144;
  localparam int GB_FRAME_PIXELS = GB_H_PIXELS * GB_V_LINES;
  localparam int FB_ADDR_W       = 15;

  typedef logic [1:0] gb_pixel_t;

endpackage

// File: rtl/gb_sync_filter.sv
// Two-flop synchroniser followed by a run-length deglitcher for one Game Boy
// control line. The second synchroniser flop doubles as the newest history
// entry, so a state change registers on the same edge that the FILTER_LEN-th
// agreeing sample enters the history.
module gb_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic state,
  output logic rise,
  output logic fall
);

  logic                  sync_meta;
  logic [FILTER_LEN-1:0] hist;
  logic [FILTER_LEN-1:0] hist_next;

  assign hist_next = {hist[FILTER_LEN-2:0], sync_meta};

  // Shift samples in and flip the filtered state only on a full agreeing run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      hist      <= '0;
      state     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_meta <= din;
      hist      <= hist_next;
      rise      <= 1'b0;
      fall      <= 1'b0;
      if ((&hist_next) && !state) begin
        state <= 1'b1;
        rise  <= 1'b1;
      end else if (!(|hist_next) && state) begin
        state <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_capture.sv
// Game Boy LCD-bus capture: filters pixel clock, hsync and vsync, counts
// pixels and issues one framebuffer write per pixel with inverted data.
module gb_capture
  import gbvga_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int DATA_DELAY = 5,
  parameter int H_PIXELS   = GB_H_PIXELS,
  parameter int V_LINES    = GB_V_LINES,
  parameter int ADDR_W     = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        idata,
  input  logic              ihsync,
  input  logic              ivsync,
  input  logic              iclk,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              frame_done,
  output logic              overrun
);

  localparam int                FRAME_INT    = H_PIXELS * V_LINES;
  localparam logic [ADDR_W-1:0] FRAME_PIXELS = FRAME_INT[ADDR_W-1:0];

  logic ck_state, ck_rise, ck_fall;
  logic hs_state, hs_rise, hs_fall;
  logic vs_state, vs_rise, vs_fall;
  logic pix_event;
  logic unused_filter_outputs;

  logic [ADDR_W-1:0] ipixel;
  gb_pixel_t         data_pipe [DATA_DELAY];

  gb_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst(rst), .din(iclk),
    .state(ck_state), .rise(ck_rise), .fall(ck_fall)
  );

  gb_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_hsync_filter (
    .clk(clk), .rst(rst), .din(ihsync),
    .state(hs_state), .rise(hs_rise), .fall(hs_fall)
  );

  gb_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_vsync_filter (
    .clk(clk), .rst(rst), .din(ivsync),
    .state(vs_state), .rise(vs_rise), .fall(vs_fall)
  );

  assign unused_filter_outputs = ck_state ^ ck_rise ^ hs_rise ^ vs_state ^ vs_fall;

  // A line start (hsync fall) is itself the first pixel; later pixels come
  // from pixel-clock falls while hsync is low. Coincident edges count once.
  assign pix_event = hs_fall | (ck_fall & ~hs_state);

  // Data delay line; the first two stages act as the synchroniser, and the
  // last stage holds the sample taken when the triggering raw edge arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DATA_DELAY; i++) data_pipe[i] <= '0;
    end else begin
      data_pipe[0] <= idata;
      for (int i = 1; i < DATA_DELAY; i++) data_pipe[i] <= data_pipe[i-1];
    end
  end

  // Pixel counter, write strobe and frame/overrun flags; vsync wins over pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ipixel     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (vs_rise) begin
        if (ipixel == FRAME_PIXELS) frame_done <= 1'b1;
        ipixel <= '0;
      end else if (pix_event) begin
        if (ipixel < FRAME_PIXELS) begin
          wr_en   <= 1'b1;
          wr_addr <= ipixel;
          wr_data <= ~data_pipe[DATA_DELAY-1];
          ipixel  <= ipixel + ADDR_W'(1);
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gb_capture.sv
// Directed bench for gb_capture, built with a reduced 8x4 frame so full
// frames and overrun fit in a short run.
module tb_gb_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int FP = H * V;

  logic        clk;
  logic        rst;
  logic [1:0]  idata;
  logic        ihsync;
  logic        ivsync;
  logic        iclk;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;
  logic        frame_done;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  logic [14:0] log_addr [64];
  logic [1:0]  log_data [64];
  int          n_wr     = 0;
  int          n_fd     = 0;
  int          n_double = 0;
  logic        prev_wr  = 1'b0;

  gb_capture #(
    .FILTER_LEN(4), .DATA_DELAY(5), .H_PIXELS(H), .V_LINES(V), .ADDR_W(15)
  ) dut (
    .clk(clk), .rst(rst), .idata(idata), .ihsync(ihsync), .ivsync(ivsync),
    .iclk(iclk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write/frame logger sampled just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (wr_en) begin
      if (n_wr < 64) begin
        log_addr[n_wr] = wr_addr;
        log_data[n_wr] = wr_data;
      end
      n_wr++;
    end
    if (frame_done) n_fd++;
    if (wr_en && prev_wr) n_double++;
    prev_wr = wr_en;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix_pulse();
    iclk = 1'b0; hold(6);
    iclk = 1'b1; hold(6);
  endtask

  task automatic line_start();
    ihsync = 1'b1; hold(6);
    ihsync = 1'b0; hold(6);
  endtask

  task automatic vsync_pulse();
    ivsync = 1'b1; hold(6);
    ivsync = 1'b0; hold(6);
  endtask

  task automatic test_reset();
    rst = 1'b1; idata = 2'b00; ihsync = 1'b0; ivsync = 1'b0; iclk = 1'b1;
    hold(3);
    checks += 5;
    if (wr_en !== 1'b0)      begin failures++; $display("[TB] FAIL reset_wr_en got=%b exp=0", wr_en); end
    if (wr_addr !== 15'd0)   begin failures++; $display("[TB] FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    if (wr_data !== 2'b00)   begin failures++; $display("[TB] FAIL reset_wr_data got=%b exp=00", wr_data); end
    if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done got=%b exp=0", frame_done); end
    if (overrun !== 1'b0)    begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
    rst = 1'b0;
    hold(10);
  endtask

  task automatic test_clean_frame();
    n_wr = 0; n_fd = 0;
    vsync_pulse();
    for (int l = 0; l < V; l++) begin
      idata = 2'b01;
      line_start();
      repeat (H - 1) pix_pulse();
    end
    hold(4);
    checks++;
    if (n_wr !== FP) begin failures++; $display("[TB] FAIL frame_write_count got=%0d exp=%0d", n_wr, FP); end
    for (int i = 0; i < FP && i < n_wr; i++) begin
      checks += 2;
      if (log_addr[i] !== 15'(i)) begin failures++; $display("[TB] FAIL frame_addr[%0d] got=%0d exp=%0d", i, log_addr[i], i); end
      if (log_data[i] !== 2'b10)  begin failures++; $display("[TB] FAIL frame_data[%0d] got=%b exp=10", i, log_data[i]); end
    end
    vsync_pulse();
    checks += 2;
    if (n_fd !== 1)       begin failures++; $display("[TB] FAIL frame_done_count got=%0d exp=1", n_fd); end
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL frame_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_glitch();
    int first_hi;
    n_wr = 0;
    iclk = 1'b0; hold(3);
    iclk = 1'b1; hold(8);
    checks++;
    if (n_wr !== 0) begin failures++; $display("[TB] FAIL glitch3_writes got=%0d exp=0", n_wr); end
    first_hi = -1;
    iclk = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (wr_en && first_hi < 0) first_hi = c;
      if (c == 4) iclk = 1'b1;
    end
    checks += 4;
    if (first_hi !== 6)       begin failures++; $display("[TB] FAIL pulse4_latency got=%0d exp=6", first_hi); end
    if (n_wr !== 1)           begin failures++; $display("[TB] FAIL pulse4_writes got=%0d exp=1", n_wr); end
    if (log_addr[0] !== 15'd0) begin failures++; $display("[TB] FAIL pulse4_addr got=%0d exp=0", log_addr[0]); end
    if (log_data[0] !== 2'b10) begin failures++; $display("[TB] FAIL pulse4_data got=%b exp=10", log_data[0]); end
    hold(6);
  endtask

  task automatic test_data_window();
    n_wr = 0;
    idata = 2'b11; ihsync = 1'b1; hold(8);
    ihsync = 1'b0; hold(1);
    idata = 2'b00; hold(10);
    idata = 2'b01; ihsync = 1'b1; hold(8);
    ihsync = 1'b0; idata = 2'b10; hold(10);
    checks += 5;
    if (n_wr !== 2)            begin failures++; $display("[TB] FAIL window_writes got=%0d exp=2", n_wr); end
    if (log_addr[0] !== 15'd1) begin failures++; $display("[TB] FAIL window_late_addr got=%0d exp=1", log_addr[0]); end
    if (log_data[0] !== 2'b00) begin failures++; $display("[TB] FAIL window_late_change got=%b exp=00", log_data[0]); end
    if (log_addr[1] !== 15'd2) begin failures++; $display("[TB] FAIL window_edge_addr got=%0d exp=2", log_addr[1]); end
    if (log_data[1] !== 2'b01) begin failures++; $display("[TB] FAIL window_edge_change got=%b exp=01", log_data[1]); end
  endtask

  task automatic test_simultaneous();
    n_wr = 0;
    idata = 2'b00; ihsync = 1'b1; hold(8);
    ihsync = 1'b0; iclk = 1'b0; hold(10);
    iclk = 1'b1; hold(8);
    checks += 2;
    if (n_wr !== 1)            begin failures++; $display("[TB] FAIL simul_writes got=%0d exp=1", n_wr); end
    if (log_addr[0] !== 15'd3) begin failures++; $display("[TB] FAIL simul_addr got=%0d exp=3", log_addr[0]); end
    pix_pulse();
    checks += 3;
    if (n_wr !== 2)            begin failures++; $display("[TB] FAIL simul_next_writes got=%0d exp=2", n_wr); end
    if (log_addr[1] !== 15'd4) begin failures++; $display("[TB] FAIL simul_next_addr got=%0d exp=4", log_addr[1]); end
    if (log_data[1] !== 2'b11) begin failures++; $display("[TB] FAIL simul_next_data got=%b exp=11", log_data[1]); end
  endtask

  task automatic test_overrun();
    n_wr = 0; n_fd = 0;
    vsync_pulse();
    checks++;
    if (n_fd !== 0) begin failures++; $display("[TB] FAIL partial_frame_done got=%0d exp=0", n_fd); end
    idata = 2'b10;
    line_start();
    repeat (FP - 1) pix_pulse();
    checks += 3;
    if (n_wr !== FP)                   begin failures++; $display("[TB] FAIL full_writes got=%0d exp=%0d", n_wr, FP); end
    if (log_addr[FP-1] !== 15'(FP - 1)) begin failures++; $display("[TB] FAIL last_addr got=%0d exp=%0d", log_addr[FP-1], FP - 1); end
    if (overrun !== 1'b0)              begin failures++; $display("[TB] FAIL overrun_early got=%b exp=0", overrun); end
    pix_pulse();
    checks += 2;
    if (n_wr !== FP)      begin failures++; $display("[TB] FAIL overrun_writes got=%0d exp=%0d", n_wr, FP); end
    if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_set got=%b exp=1", overrun); end
    pix_pulse();
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_sticky got=%b exp=1", overrun); end
    vsync_pulse();
    checks += 2;
    if (n_fd !== 1)       begin failures++; $display("[TB] FAIL overrun_frame_done got=%0d exp=1", n_fd); end
    if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_after_vsync got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_midframe();
    n_wr = 0;
    idata = 2'b00;
    line_start();
    repeat (19) pix_pulse();
    checks += 3;
    if (n_wr !== 20)       begin failures++; $display("[TB] FAIL mid_writes got=%0d exp=20", n_wr); end
    if (wr_addr !== 15'd19) begin failures++; $display("[TB] FAIL mid_addr got=%0d exp=19", wr_addr); end
    if (wr_data !== 2'b11) begin failures++; $display("[TB] FAIL mid_data got=%b exp=11", wr_data); end
    rst = 1'b1;
    #1;
    checks += 5;
    if (wr_en !== 1'b0)      begin failures++; $display("[TB] FAIL async_wr_en got=%b exp=0", wr_en); end
    if (wr_addr !== 15'd0)   begin failures++; $display("[TB] FAIL async_wr_addr got=%0d exp=0", wr_addr); end
    if (wr_data !== 2'b00)   begin failures++; $display("[TB] FAIL async_wr_data got=%b exp=00", wr_data); end
    if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL async_frame_done got=%b exp=0", frame_done); end
    if (overrun !== 1'b0)    begin failures++; $display("[TB] FAIL async_overrun got=%b exp=0", overrun); end
    hold(3);
    rst = 1'b0;
    hold(10);
    n_wr = 0;
    idata = 2'b01;
    vsync_pulse();
    line_start();
    repeat (2) pix_pulse();
    checks++;
    if (n_wr !== 3) begin failures++; $display("[TB] FAIL restart_writes got=%0d exp=3", n_wr); end
    for (int i = 0; i < 3 && i < n_wr; i++) begin
      checks += 2;
      if (log_addr[i] !== 15'(i)) begin failures++; $display("[TB] FAIL restart_addr[%0d] got=%0d exp=%0d", i, log_addr[i], i); end
      if (log_data[i] !== 2'b10)  begin failures++; $display("[TB] FAIL restart_data[%0d] got=%b exp=10", i, log_data[i]); end
    end
  endtask

  task automatic test_no_back_to_back();
    checks++;
    if (n_double !== 0) begin failures++; $display("[TB] FAIL wr_en_consecutive got=%0d exp=0", n_double); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_glitch();
    test_data_window();
    test_simultaneous();
    test_overrun();
    test_reset_midframe();
    test_no_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
